mem_a_loader: RTL and testbench

- Upstream feeder for the A-matrix row memory of the systolic matrix unit.
- Accepts a packed word stream from the host/DMA side over a valid/ready handshake and assembles DIM signed elements into one row.
- Writes each row into the A memory with a one-cycle write pulse and row index, for rows 0..DIM-1 in order.
- Signals completion with a one-cycle done pulse.

---
 rtl/mem_a_loader.sv | 134 +++++++++++++
 tb/tb_mem_a_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_a_loader.sv
// mem_a_loader: assembles packed input words into DIM-element rows and
// writes them, in order, into the A-matrix row memory of the systolic unit.
module mem_a_loader #(
  parameter int BITS_AB   = 8,
  parameter int DIM       = 8,
  parameter int WORD_BITS = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [WORD_BITS-1:0]                in_data,
  output logic                                in_ready,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  output logic [$clog2(DIM)-1:0]              Arow,
  output logic                                WrEn,
  output logic                                busy,
  output logic                                done
);

  localparam int ROW_BITS = DIM * BITS_AB;
  localparam int BPR      = ROW_BITS / WORD_BITS;
  localparam int BW       = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW       = $clog2(DIM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [RW-1:0]       rowc_q, rowc_d;
  logic [ROW_BITS-1:0] buf_q, buf_d;
  logic [ROW_BITS-1:0] ain_q, ain_d;
  logic [RW-1:0]       arow_q, arow_d;
  logic                wren_q, ready_q, busy_q, done_q;

  assign Ain      = ain_q;
  assign Arow     = arow_q;
  assign WrEn     = wren_q;
  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, counter and row-assembly logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rowc_d  = rowc_q;
    buf_d   = buf_q;
    ain_d   = ain_q;
    arow_d  = arow_q;
    if (clear) begin
      state_d = S_IDLE;
      beat_d  = '0;
      rowc_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            beat_d  = '0;
            rowc_d  = '0;
          end
        end
        S_LOAD: begin
          if (in_valid && ready_q) begin
            for (int unsigned b = 0; b < BPR; b++) begin
              if (beat_q == BW'(b)) begin
                buf_d[b*WORD_BITS +: WORD_BITS] = in_data;
              end
            end
            if (beat_q == BW'(BPR - 1)) begin
              // Latch the completed row (including this beat) for the write.
              state_d = S_WRITE;
              beat_d  = '0;
              ain_d   = buf_d;
              arow_d  = rowc_q;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (rowc_q == RW'(DIM - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            rowc_d  = rowc_q + 1'b1;
            beat_d  = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters, row buffer and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rowc_q  <= '0;
      buf_q   <= '0;
      ain_q   <= '0;
      arow_q  <= '0;
      wren_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rowc_q  <= rowc_d;
      buf_q   <= buf_d;
      ain_q   <= ain_d;
      arow_q  <= arow_d;
      wren_q  <= (state_d == S_WRITE);
      ready_q <= (state_d == S_LOAD);
      busy_q  <= (state_d == S_LOAD) || (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_mem_a_loader.sv
// tb_mem_a_loader: directed table-driven loads, clear/reset corner cases and
// a randomized run against a behavioural row-stream model.
module tb_mem_a_loader;

  localparam int DIM = 8;
  localparam int BPR = 2;

  logic                      clk = 1'b0;
  logic                      rst_n, start, clear, in_valid;
  logic [31:0]               in_data;
  logic                      in_ready, WrEn, busy, done;
  logic signed [7:0][7:0]    Ain;
  logic [2:0]                Arow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc0  = 0;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic [63:0] exp_row;
    int          exp_arow;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[8];

  mem_a_loader #(.BITS_AB(8), .DIM(8), .WORD_BITS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .Ain      (Ain),
    .Arow     (Arow),
    .WrEn     (WrEn),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_wren",  WrEn, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_arow",  Arow, 0);
    chk("rst_ain",   Ain, 0);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Called at a sample point with the loader in LOAD; feeds one row back to back.
  task automatic run_row(input int r, input logic [31:0] next_w, input logic next_v);
    chk("ready_b0", in_ready, 1);
    in_valid = 1'b1; in_data = tbl[r].b0;
    tick;
    chk("ready_b1", in_ready, 1);
    in_data = tbl[r].b1;
    tick;
    chk("wren",     WrEn, 1);
    chk("arow",     Arow, tbl[r].exp_arow);
    chk("ain",      Ain, tbl[r].exp_row);
    chk("ready_wr", in_ready, 0);
    chk("busy_wr",  busy, 1);
    chk("wr_cycle", cyc - cyc0, tbl[r].exp_cyc);
    in_valid = next_v; in_data = next_w;
    tick;
  endtask

  task automatic do_load(input logic hold_start);
    in_valid = 1'b0; start = 1'b1; cyc0 = cyc;
    tick;
    start = hold_start;
    for (int r = 0; r < DIM; r++)
      run_row(r, (r < DIM - 1) ? tbl[r+1].b0 : 32'hdeadbeef, 1'b1);
    chk("done_pulse", done, 1);
    chk("done_busy",  busy, 0);
    chk("done_wren",  WrEn, 0);
    chk("done_ready", in_ready, 0);
    chk("done_cycle", cyc - cyc0, 25);
    chk("hold_ain",   Ain, tbl[DIM-1].exp_row);
    chk("hold_arow",  Arow, DIM - 1);
    start = 1'b0; in_valid = 1'b0;
    tick;
    chk("post_done",  done, 0);
    chk("post_busy",  busy, 0);
    chk("post_ready", in_ready, 0);
    tick;
    chk("idle_busy",  busy, 0);
    chk("idle_done",  done, 0);
  endtask

  // Randomized traffic checked against a model of the row stream.
  task automatic run_model(input int n);
    logic        e_ready = 0, e_busy = 0, e_wr = 0, e_done = 0;
    logic [63:0] e_ain = '0;
    int          e_arow = 0, rows = 0, beats = 0;
    logic [31:0] words[BPR];
    logic        v, st, cl;
    logic [31:0] d;
    logic [63:0] rv;
    for (int i = 0; i < n; i++) begin
      chk("m_ready", in_ready, e_ready);
      chk("m_busy",  busy, e_busy);
      chk("m_wren",  WrEn, e_wr);
      chk("m_done",  done, e_done);
      chk("m_arow",  Arow, e_arow);
      chk("m_ain",   Ain, e_ain);
      if (i < n / 2) begin
        v  = ($urandom_range(9) < 6);
        cl = ($urandom_range(63) == 0);
        st = ($urandom_range(5) == 0);
      end else begin
        v  = ((i % 4) == 0) || ((i % 4) == 3);
        cl = 1'b0;
        st = ($urandom_range(7) == 0);
      end
      d = $urandom;
      in_valid = v; clear = cl; start = st; in_data = d;
      if (cl) begin
        e_ready = 0; e_busy = 0; e_wr = 0; e_done = 0;
      end else if (e_done) begin
        e_done = 0;
      end else if (e_wr) begin
        e_wr = 0;
        if (rows == DIM) begin
          e_busy = 0; e_done = 1;
        end else begin
          e_ready = 1;
        end
      end else if (e_ready) begin
        if (v) begin
          words[beats] = d;
          beats++;
          if (beats == BPR) begin
            rv = '0;
            for (int w = BPR - 1; w >= 0; w--) rv = (rv << 32) | 64'(words[w]);
            e_ain = rv; e_arow = rows; rows++; beats = 0;
            e_wr = 1; e_ready = 0;
          end
        end
      end else if (st) begin
        e_ready = 1; e_busy = 1; rows = 0; beats = 0;
      end
      tick;
    end
    in_valid = 1'b0; clear = 1'b0; start = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < DIM; r++) begin
      tbl[r].b0       = {8'h83, 8'(r), 8'h01, 8'h00};
      tbl[r].b1       = 32'h07060504;
      tbl[r].exp_row  = {8'sd7, 8'sd6, 8'sd5, 8'sd4, -8'sd125, 8'(r), 8'sd1, 8'sd0};
      tbl[r].exp_arow = r;
      tbl[r].exp_cyc  = 3 * (r + 1);
    end

    do_reset;

    // Basic load with start held high through LOAD and DONE (must be ignored).
    do_load(1'b1);

    // Clear after three rows plus one beat of row 3; the clearing beat is dropped.
    in_valid = 1'b0; start = 1'b1; cyc0 = cyc;
    tick;
    start = 1'b0;
    for (int r = 0; r < 3; r++) run_row(r, tbl[r+1].b0, 1'b1);
    tick;
    in_data = tbl[3].b1; clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_ready", in_ready, 0);
    chk("clr_busy",  busy, 0);
    chk("clr_wren",  WrEn, 0);
    chk("clr_done",  done, 0);
    chk("clr_arow",  Arow, 2);
    chk("clr_ain",   Ain, tbl[2].exp_row);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("clr_nowr", WrEn, 0);
      chk("clr_idle", busy, 0);
    end
    do_load(1'b0);

    // Asynchronous reset during the write of row 5.
    in_valid = 1'b0; start = 1'b1; cyc0 = cyc;
    tick;
    start = 1'b0;
    for (int r = 0; r < 5; r++) run_row(r, tbl[r+1].b0, 1'b1);
    in_data = tbl[5].b0;
    tick;
    in_data = tbl[5].b1;
    tick;
    chk("wren_r5", WrEn, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren",  WrEn, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_done",  done, 0);
    chk("arst_arow",  Arow, 0);
    chk("arst_ain",   Ain, 0);
    start = 1'b1; in_valid = 1'b1;
    tick;
    tick;
    chk("arst_start_busy",  busy, 0);
    chk("arst_start_ready", in_ready, 0);
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    tick;
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_wren", WrEn, 0);

    do_reset;
    run_model(1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
